axil_master: RTL and testbench

- Single-outstanding AXI4-Lite initiator that converts a simple request/response port into AXI-Lite read and write transactions.
- Sits between an internal requester (CPU load/store unit, debug bridge) and the AXI-Lite interconnect that feeds peripheral responders such as the GPIO block.
- Performs one transaction at a time; the AW and W channels are issued concurrently.

---
 rtl/axil_pkg.sv | 30 +++
 rtl/axil_master.sv | 203 ++++++++++++++++++++
 tb/tb_axil_master.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, initiator state encoding
// and the request bundle used by axil_master and the peripheral responders.
package axil_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam int AXIL_ADDR_W = 32;
    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WB,
        RA,
        RD,
        RSP
    } axil_state_t;

    typedef struct packed {
        logic                   write;
        logic [AXIL_ADDR_W-1:0] addr;
        logic [AXIL_DATA_W-1:0] wdata;
        logic [AXIL_STRB_W-1:0] wstrb;
    } axil_req_t;

endpackage

// File: rtl/axil_master.sv
// Single-outstanding AXI4-Lite initiator: turns one request/response pair
// into one AXI-Lite read or write (AW and W issued together).
// Ports:
//   clk, rst                     clock, async active-high reset
//   req_valid/ready/write/addr/wdata/wstrb   request port
//   rsp_valid/ready/rdata/resp   response port (rdata is 0 for writes)
//   aw*/w*/b*/ar*/r*             AXI-Lite master channels, all registered
// Optional macro AXIL_MASTER_TIMEOUT_EN: response watchdog that gives up
// after TIMEOUT_CYCLES quiet cycles, answers SLVERR and discards the late
// beat via a sticky stale flag.
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [STRB_WIDTH-1:0] req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [STRB_WIDTH-1:0] wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64) || TIMEOUT_CYCLES < 2)
    begin : g_cfg_check
        $error("axil_master: unsupported DATA_WIDTH or TIMEOUT_CYCLES");
    end

    axil_state_t state;

    assign awprot = 3'b000;
    assign arprot = 3'b000;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt;
    logic          busy;
    logic          hs;
    logic          tmo;
    logic          stale;

    assign busy = (state == WR) || (state == WB) ||
                  (state == RA) || (state == RD);
    assign hs   = (awvalid && awready) || (wvalid && wready) ||
                  (bvalid && bready)   || (arvalid && arready) ||
                  (rvalid && rready);
    // Fires on the last quiet cycle so the giveup lands exactly
    // TIMEOUT_CYCLES cycles after the last handshake.
    assign tmo  = busy && !hs && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!busy || hs) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= '0;
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
`ifdef AXIL_MASTER_TIMEOUT_EN
            stale     <= 1'b0;
`endif
`ifdef AXIL_MASTER_TIMEOUT_EN
        end else if (tmo) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            arvalid   <= 1'b0;
            bready    <= 1'b0;
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_resp  <= SLVERR;
            rsp_rdata <= '0;
            stale     <= 1'b1;
            state     <= RSP;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
`ifdef AXIL_MASTER_TIMEOUT_EN
                    // Swallow the beat belonging to the abandoned transfer.
                    if (stale && ((bvalid && bready) || (rvalid && rready))) begin
                        stale  <= 1'b0;
                        bready <= 1'b0;
                        rready <= 1'b0;
                    end
`endif
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        bready    <= 1'b0;
                        rready    <= 1'b0;
                        if (req_write) begin
                            awaddr  <= req_addr;
                            wdata   <= req_wdata;
                            wstrb   <= req_wstrb;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR;
                        end else begin
                            araddr  <= req_addr;
                            arvalid <= 1'b1;
                            state   <= RA;
                        end
                    end
                end
                WR: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready) wvalid <= 1'b0;
                    // A channel is done once its valid is low or handshaking now.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WB;
                    end
                end
                WB: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        rsp_resp  <= bresp;
                        rsp_rdata <= '0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RA: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD;
                    end
                end
                RD: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        rsp_rdata <= rdata;
                        rsp_resp  <= rresp;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
`ifdef AXIL_MASTER_TIMEOUT_EN
                        bready    <= stale;
                        rready    <= stale;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: directed vector table, randomized
// transactions against a memory reference model, reset and watchdog cases.
module tb_axil_master;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    always #5 clk = ~clk;

    axil_master #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- responder ----------------
    int aw_wait, w_wait, b_wait, ar_wait, r_wait;
    logic [1:0] b_code, r_code;
    bit b_hold;
    int aw_age, w_age, b_age, ar_age, r_age;
    bit aw_got, w_got, b_pend, r_pend;
    int n_aw, n_w, n_b, n_ar, n_r;
    int proto_err = 0;
    logic [31:0] wr_addr, wr_data, rd_addr;
    logic [3:0]  wr_strb;
    bit pv_aw, pv_w, pv_ar;
    logic [31:0] p_awaddr, p_wdata, p_araddr;
    logic [3:0]  p_wstrb;
    logic [31:0] rmem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        return rmem.exists(k) ? rmem[k] : 32'h0;
    endfunction

    task automatic resp_clear();
        aw_age = 0; w_age = 0; b_age = 0; ar_age = 0; r_age = 0;
        aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
        pv_aw = 0; pv_w = 0; pv_ar = 0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    endtask

    initial begin
        bit s_aw, s_w, s_b, s_ar, s_r, s_awv, s_wv, s_arv;
        logic [31:0] s_awaddr, s_wdata, s_araddr, old;
        logic [3:0]  s_wstrb;
        resp_clear();
        forever begin
            @(negedge clk);
            s_aw = awvalid && awready; s_w = wvalid && wready;
            s_b = bvalid && bready; s_ar = arvalid && arready;
            s_r = rvalid && rready;
            s_awv = awvalid; s_wv = wvalid; s_arv = arvalid;
            s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb;
            s_araddr = araddr;
            if (!rst) begin
                if (pv_aw && !(awvalid && awaddr == p_awaddr)) proto_err++;
                if (pv_w && !(wvalid && wdata == p_wdata && wstrb == p_wstrb))
                    proto_err++;
                if (pv_ar && !(arvalid && araddr == p_araddr)) proto_err++;
                pv_aw = awvalid && !awready; p_awaddr = awaddr;
                pv_w = wvalid && !wready; p_wdata = wdata; p_wstrb = wstrb;
                pv_ar = arvalid && !arready; p_araddr = araddr;
            end
            @(posedge clk);
            #1;
            if (rst) begin
                resp_clear();
                continue;
            end
            if (s_r) begin n_r++; r_pend = 0; end
            else if (r_pend) r_age++;
            if (s_ar) begin
                n_ar++; r_pend = 1; r_age = 0; rd_addr = s_araddr; ar_age = 0;
            end else if (s_arv) ar_age++;
            else ar_age = 0;
            if (s_b) begin n_b++; b_pend = 0; end
            else if (b_pend) b_age++;
            if (s_aw) begin n_aw++; aw_got = 1; wr_addr = s_awaddr; aw_age = 0; end
            else if (s_awv) aw_age++;
            else aw_age = 0;
            if (s_w) begin
                n_w++; w_got = 1; wr_data = s_wdata; wr_strb = s_wstrb; w_age = 0;
            end else if (s_wv) w_age++;
            else w_age = 0;
            if (aw_got && w_got) begin
                old = mem_rd(wr_addr);
                for (int b = 0; b < 4; b++)
                    if (wr_strb[b]) old[8*b +: 8] = wr_data[8*b +: 8];
                rmem[{wr_addr[31:2], 2'b00}] = old;
                b_pend = 1; b_age = 0; aw_got = 0; w_got = 0;
            end
            awready = awvalid && (aw_age >= aw_wait);
            wready  = wvalid && (w_age >= w_wait);
            bvalid  = b_pend && !b_hold && (b_age >= b_wait);
            bresp   = bvalid ? b_code : 2'b00;
            arready = arvalid && (ar_age >= ar_wait);
            rvalid  = r_pend && (r_age >= r_wait);
            rdata   = rvalid ? mem_rd(rd_addr) : 32'h0;
            rresp   = rvalid ? r_code : 2'b00;
        end
    end

    // ---------------- transaction driver ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aww, ww, bw, arw, rw;
        logic [1:0]  code;
        int          hold;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        int          exp_lat;
    } vec_t;

    function automatic vec_t mk(bit wr, logic [31:0] a, logic [31:0] d,
                                logic [3:0] s, int aww, int ww, int bw,
                                int arw, int rw, logic [1:0] code, int hold,
                                logic [31:0] er, logic [1:0] es, int el);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.strb = s;
        v.aww = aww; v.ww = ww; v.bw = bw; v.arw = arw; v.rw = rw;
        v.code = code; v.hold = hold;
        v.exp_rdata = er; v.exp_resp = es; v.exp_lat = el;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, output logic [31:0] rd,
                           output logic [1:0] rs, output int lat,
                           output bit got, output bit hold_ok,
                           output bit rr_after);
        aw_wait = v.aww; w_wait = v.ww; b_wait = v.bw;
        ar_wait = v.arw; r_wait = v.rw;
        b_code = v.code; r_code = v.code;
        n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
        rd = '0; rs = '0; lat = 0; got = 0; hold_ok = 1; rr_after = 0;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        if (!req_ready) return;
        req_valid = 1; req_write = v.wr; req_addr = v.addr;
        req_wdata = v.wdata; req_wstrb = v.strb;
        rsp_ready = (v.hold == 0);
        @(negedge clk);
        req_valid = 0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) begin
            rsp_ready = 1;
            return;
        end
        got = 1; rd = rsp_rdata; rs = rsp_resp;
        for (int k = 0; k < v.hold; k++) begin
            if (!(rsp_valid && rsp_rdata == rd && rsp_resp == rs && !req_ready))
                hold_ok = 0;
            @(negedge clk);
        end
        if (!(rsp_valid && rsp_rdata == rd && rsp_resp == rs)) hold_ok = 0;
        rsp_ready = 1;
        @(negedge clk);
        rr_after = req_ready && !rsp_valid;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vec [11];
        vec_t        v;
        logic [31:0] rd, ref_mem [8], exp_d;
        logic [1:0]  rs;
        int          lat, extra, idx;
        bit          got, hold_ok, rr, hs_ok;

        rst = 1; req_valid = 0; req_write = 0; req_addr = 0;
        req_wdata = 0; req_wstrb = 0; rsp_ready = 1; b_hold = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        b_code = 0; r_code = 0;
        for (int i = 0; i < 8; i++) ref_mem[i] = 32'h0;

        repeat (3) @(negedge clk);
        check("rst req_ready", req_ready, 0);
        check("rst valids", {awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
        check("rst awaddr/araddr", {awaddr, araddr}, 0);
        check("rst rsp", {rsp_rdata, rsp_resp}, 0);
        check("prot", {awprot, arprot}, 0);
        rst = 0;
        @(negedge clk);
        check("req_ready after reset", req_ready, 1);

        //         wr addr   wdata         strb aw w b ar r code  hold exp_rdata    resp  lat
        vec[0]  = mk(1, 'h4,  'hDEADBEEF, 'hF, 0, 0, 0, 0, 0, 2'd0, 0, 'h0,        2'd0, 3);
        vec[1]  = mk(1, 'h8,  'h12345678, 'hF, 3, 0, 0, 0, 0, 2'd0, 0, 'h0,        2'd0, 0);
        vec[2]  = mk(0, 'h8,  'h0,        'h0, 0, 0, 0, 2, 5, 2'd0, 0, 'h12345678, 2'd0, 0);
        vec[3]  = mk(0, 'h4,  'h0,        'h0, 0, 0, 0, 0, 0, 2'd3, 4, 'hDEADBEEF, 2'd3, 0);
        vec[4]  = mk(1, 'h4,  'hAABBCCDD, 'h5, 0, 0, 0, 0, 0, 2'd2, 0, 'h0,        2'd2, 0);
        vec[5]  = mk(0, 'h4,  'h0,        'h0, 0, 0, 0, 0, 0, 2'd0, 0, 'hDEBBBEDD, 2'd0, 3);
        vec[6]  = mk(1, 'hC,  'hCAFEF00D, 'hC, 2, 2, 1, 0, 0, 2'd1, 0, 'h0,        2'd1, 0);
        vec[7]  = mk(0, 'hC,  'h0,        'h0, 0, 0, 0, 1, 1, 2'd1, 0, 'hCAFE0000, 2'd1, 0);
        vec[8]  = mk(0, 'h10, 'h0,        'h0, 0, 0, 0, 2, 0, 2'd0, 0, 'h0,        2'd0, 0);
        vec[9]  = mk(1, 'h10, 'h0BADC0DE, 'h3, 0, 3, 2, 0, 0, 2'd3, 2, 'h0,        2'd3, 0);
        vec[10] = mk(0, 'h10, 'h0,        'h0, 0, 0, 0, 0, 3, 2'd0, 0, 'h0000C0DE, 2'd0, 0);

        for (int i = 0; i < 11; i++) begin
            run_txn(vec[i], rd, rs, lat, got, hold_ok, rr);
            check($sformatf("v%0d rsp seen", i), got, 1);
            check($sformatf("v%0d rdata", i), rd, vec[i].exp_rdata);
            check($sformatf("v%0d resp", i), rs, vec[i].exp_resp);
            hs_ok = vec[i].wr ? (n_aw == 1 && n_w == 1 && n_b == 1 && n_ar == 0 && n_r == 0)
                              : (n_aw == 0 && n_w == 0 && n_b == 0 && n_ar == 1 && n_r == 1);
            check($sformatf("v%0d handshakes", i), hs_ok, 1);
            if (vec[i].exp_lat != 0) begin
                check($sformatf("v%0d latency", i), lat, vec[i].exp_lat);
                check($sformatf("v%0d req_ready again", i), rr, 1);
            end
            if (vec[i].hold != 0)
                check($sformatf("v%0d rsp held", i), hold_ok, 1);
        end

        for (int t = 0; t < 40; t++) begin
            idx = $urandom_range(0, 7);
            v = mk($urandom_range(0, 1) == 1, 32'h100 + 32'(idx) * 4, $urandom,
                   4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3),
                   2'($urandom_range(0, 3)), $urandom_range(0, 2),
                   32'h0, 2'd0, 0);
            exp_d = v.wr ? 32'h0 : ref_mem[idx];
            run_txn(v, rd, rs, lat, got, hold_ok, rr);
            check($sformatf("rnd%0d rdata", t), {got, rd}, {1'b1, exp_d});
            check($sformatf("rnd%0d resp", t), rs, v.code);
            if (v.wr)
                for (int b = 0; b < 4; b++)
                    if (v.strb[b]) ref_mem[idx][8*b +: 8] = v.wdata[8*b +: 8];
        end

`ifdef AXIL_MASTER_TIMEOUT_EN
        b_hold = 1;
        v = mk(1, 'h20, 'h11112222, 'hF, 0, 0, 0, 0, 0, 2'd0, 0, 'h0, 2'd2, 0);
        run_txn(v, rd, rs, lat, got, hold_ok, rr);
        check("tmo rsp seen", got, 1);
        check("tmo resp", {rd, rs}, {32'h0, 2'b10});
        check("tmo latency", lat, 2 + TO);
        check("tmo no b yet", n_b, 0);
        check("stale bready", bready, 1);
        b_hold = 0;
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid) extra++;
        end
        check("late b taken", n_b, 1);
        check("no extra rsp", extra, 0);
        check("stale cleared", bready, 0);
`endif

        aw_wait = 0; w_wait = 0; b_wait = 20; b_code = 0;
        for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
        req_valid = 1; req_write = 1; req_addr = 'h30;
        req_wdata = 'h55; req_wstrb = 'hF;
        @(negedge clk);
        req_valid = 0;
        for (int k = 0; k < 20 && !bready; k++) @(negedge clk);
        check("reached WB", bready, 1);
        rst = 1;
        #1;
        check("rst mid-txn outputs",
              {awvalid, wvalid, bready, arvalid, rready, rsp_valid, req_ready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("req_ready after mid reset", req_ready, 1);
        v = mk(0, 'h4, 'h0, 'h0, 0, 0, 0, 0, 0, 2'd0, 0, 'hDEBBBEDD, 2'd0, 3);
        run_txn(v, rd, rs, lat, got, hold_ok, rr);
        check("post-reset read", {got, rd, rs}, {1'b1, 32'hDEBBBEDD, 2'b00});
        check("post-reset latency", lat, 3);

        check("protocol stability", proto_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
